fp_cvt_sd: RTL and testbench
============================

# fp_cvt_sd

Single-to-double precision converter (RISC-V FCVT.D.S) for the D-extension ALU, the widening counterpart of the double-to-single narrowing path.
- Accepts an IEEE-754 binary32 operand over a valid/ready handshake and returns the exact binary64 value over a second valid/ready handshake. No rounding is ever needed.
- Normal, zero, infinity and NaN operands complete in one cycle.
- Single-precision subnormals are normalized iteratively, one bit per cycle, because every binary32 subnormal becomes a binary64 normal.
- The block sits between operand issue and the ALU result writeback mux.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. One clock domain.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand. High only in IDLE.
- in_s  input  32  binary32 operand, sampled when in_valid && in_ready.
- out_valid  output  1  result valid. High only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_d  output  64  binary64 result. Stable while out_valid is high.
- out_nv  output  1  invalid-operation flag, valid with out_d.

## Operation
FSM states are IDLE, NORM and DONE.

Classification at acceptance, with s, e[7:0] and f[22:0] taken from in_s:
- e=FF, f≠0: NaN. out_d = 64'h7FF8_0000_0000_0000 (canonical, sign dropped). out_nv = ~f[22], so it is 1 for a signalling NaN. Next state DONE.
- e=FF, f=0: out_d = {s, 11'h7FF, 52'b0}. Next state DONE.
- e=0, f=0: out_d = {s, 63'b0}. Next state DONE.
- 1≤e≤FE: out_d = {s, e+11'd896, f, 29'b0}, with e zero-extended to 11 bits. Next state DONE.
- e=0, f≠0: load m[23:0] = {1'b0, f} and x[10:0] = 11'd897, latch s, then go to NORM.
- out_nv is 0 in every case except the signalling NaN.

NORM state, each cycle:
- m ← m<<1, x ← x−1.
- If the pre-shift m[22] was 1, register out_d = {s, x−1, m[21:0], 30'b0}, which equals the new m[22:0] followed by 29 zeros. Then go to DONE.
- Otherwise stay in NORM.

DONE state:
- out_valid = 1.
- On out_ready, go to IDLE.

Rules:
- in_ready = (state == IDLE). Operands are never accepted in NORM or DONE, whatever in_valid does.
- Arithmetic widths: x is 11-bit unsigned and never underflows, since its minimum is 874. m is 24 bits.
- Conversion is exact for all 2^32 inputs. The output exponent range is 874..1150.

## Timing
- Reset, asynchronous assert: state IDLE, out_valid 0, out_d 0, out_nv 0, m 0, x 0. in_ready reads 1 while in reset.
- Reset asserted mid-operation, in NORM or DONE: the in-flight result is discarded and no out_valid is produced.
- Latency is counted in rising edges from the acceptance edge to the first cycle with out_valid high:
  - Non-subnormal operand: 1.
  - Subnormal operand whose f MSB is at bit p (0..22): 1 + (23 − p). This ranges from 2 (p=22) to 24 (p=0).
- Throughput with out_ready held high: one non-subnormal result every 2 cycles. Acceptance and output never overlap.
- Backpressure: out_valid, out_d and out_nv hold unchanged while out_ready is low, for any number of cycles.
- The cycle after the output handshake: out_valid is 0 and in_ready is 1.
- in_valid may be high during NORM or DONE. It has no effect, and the same operand is accepted on the first IDLE cycle.

## Test plan
- 3F80_0000 (1.0) → 3FF0_0000_0000_0000, out_nv 0, latency 1. Also 7F7F_FFFF → 47EF_FFFF_E000_0000.
- 8000_0000 → 8000_0000_0000_0000. FF80_0000 → FFF0_0000_0000_0000. Both have latency 1 and out_nv 0.
- 7F80_0001 (signalling NaN) → 7FF8_0000_0000_0000 with out_nv 1. FFC0_0000 (quiet NaN) → 7FF8_0000_0000_0000 with out_nv 0.
- 0000_0001 → 36A0_0000_0000_0000, latency 24, in_ready low throughout. 007F_FFFF → 380F_FFFF_C000_0000, latency 2.
- Backpressure: hold out_ready low for 5 cycles in DONE while in_valid is high with a new operand. Required: out_d stable, in_ready 0, and the new operand accepted only in the cycle after the handshake.
- Reset pulse during NORM on 0000_0001: all outputs return to their reset values, no result appears, and the next operand 3F80_0000 converts normally.

Source files
------------

// File: rtl/fp_cvt_sd.sv
// rtl/fp_cvt_sd.sv - binary32 to binary64 widening converter with iterative subnormal normalization
module fp_cvt_sd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_d,
    output logic        out_nv
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    state_t      state, state_next;
    logic [23:0] m, m_next;
    logic [10:0] x, x_next;
    logic        s_r, s_next;
    logic [63:0] d_next;
    logic        nv_next;

    logic        sgn;
    logic [7:0]  exp8;
    logic [22:0] frac;
    logic [10:0] x_dec;

    assign sgn   = in_s[31];
    assign exp8  = in_s[30:23];
    assign frac  = in_s[22:0];
    assign x_dec = x - 11'd1;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            m      <= '0;
            x      <= '0;
            s_r    <= 1'b0;
            out_d  <= '0;
            out_nv <= 1'b0;
        end else begin
            state  <= state_next;
            m      <= m_next;
            x      <= x_next;
            s_r    <= s_next;
            out_d  <= d_next;
            out_nv <= nv_next;
        end
    end

    always_comb begin
        state_next = state;
        m_next     = m;
        x_next     = x;
        s_next     = s_r;
        d_next     = out_d;
        nv_next    = out_nv;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s_next  = sgn;
                    nv_next = 1'b0;
                    if (exp8 == 8'hFF) begin
                        state_next = DONE;
                        if (frac != 23'd0) begin
                            d_next  = CANON_NAN;
                            nv_next = ~frac[22];
                        end else begin
                            d_next = {sgn, 11'h7FF, 52'd0};
                        end
                    end else if (exp8 == 8'h00) begin
                        if (frac == 23'd0) begin
                            d_next     = {sgn, 63'd0};
                            state_next = DONE;
                        end else begin
                            // Subnormal: walk the leading one up to bit 22, one step per cycle.
                            m_next     = {1'b0, frac};
                            x_next     = 11'd897;
                            state_next = NORM;
                        end
                    end else begin
                        d_next     = {sgn, {3'b000, exp8} + 11'd896, frac, 29'd0};
                        state_next = DONE;
                    end
                end
            end
            NORM: begin
                m_next = m << 1;
                x_next = x_dec;
                if (m[22]) begin
                    // The bit now leaving is the hidden one; the remainder is the fraction.
                    d_next     = {s_r, x_dec, m[21:0], 30'd0};
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_cvt_sd.sv
// tb/tb_fp_cvt_sd.sv - self-checking bench for fp_cvt_sd with a value-level conversion model
module tb_fp_cvt_sd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_d;
    logic        out_nv;

    logic [63:0] lit_d;
    logic        lit_nv;
    int          lit_lat;

    int n_checks = 0;
    int n_fail   = 0;

    fp_cvt_sd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_nv    (out_nv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value model: real exponent is e-127 (normal) or p-149 (subnormal, MSB at p); rebias by 1023.
    function automatic void model(input logic [31:0] v, output logic [63:0] d,
                                  output logic nv, output int lat);
        int          e;
        int          p;
        logic [63:0] fr;
        e   = int'(v[30:23]);
        nv  = 1'b0;
        lat = 1;
        p   = 0;
        if (e == 255 && v[22:0] != 0) begin
            d  = 64'h7FF8_0000_0000_0000;
            nv = (v[22] == 1'b0);
        end else if (e == 255) begin
            d = {v[31], 11'h7FF, 52'd0};
        end else if (e == 0 && v[22:0] == 0) begin
            d = {v[31], 63'd0};
        end else if (e == 0) begin
            for (int i = 0; i < 23; i++) if (v[i]) p = i;
            fr  = 64'(v[22:0]) << (52 - p);
            d   = {v[31], 11'(p - 149 + 1023), fr[51:0]};
            lat = 1 + (23 - p);
        end else begin
            fr = 64'(v[22:0]) << 29;
            d  = {v[31], 11'(e - 127 + 1023), fr[51:0]};
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    int          cyc = 0;
    int          acc_cyc = 0;
    int          stall = 0;
    logic        pending = 1'b0;
    logic [63:0] exp_d = '0;
    logic        exp_nv = 1'b0;
    int          exp_lat = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_nv = 1'b0;

    always @(negedge clk) begin : compare
        logic [63:0] md;
        logic        mnv;
        int          mlat;
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_d", out_d, 64'd0);
            chk("rst_out_nv", 64'(out_nv), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            pending    = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            stall      = 0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_d", out_d, prev_d);
                chk("hold_nv", 64'(out_nv), 64'(prev_nv));
            end
            if (prev_valid && prev_ready) begin
                chk("post_hs_valid", 64'(out_valid), 64'd0);
                chk("post_hs_in_ready", 64'(in_ready), 64'd1);
            end
            if (out_valid) begin
                if (!pending) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("out_d", out_d, exp_d);
                    chk("out_nv", 64'(out_nv), 64'(exp_nv));
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                    if (!prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
                    if (out_ready) pending = 1'b0;
                end
            end else if (pending && (cyc - acc_cyc) > 30) begin
                chk("result_timeout", 64'(cyc - acc_cyc), 64'(exp_lat));
                pending = 1'b0;
            end
            if (in_valid && in_ready) begin
                model(in_s, md, mnv, mlat);
                chk("model_d", md, lit_d);
                chk("model_nv", 64'(mnv), 64'(lit_nv));
                chk("model_lat", 64'(mlat), 64'(lit_lat));
                exp_d   = md;
                exp_nv  = mnv;
                exp_lat = mlat;
                acc_cyc = cyc;
                pending = 1'b1;
            end
            if (in_valid && !in_ready) stall++;
            else stall = 0;
            if (stall == 40) chk("accept_stall", 64'(stall), 64'd0);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_d     = out_d;
            prev_nv    = out_nv;
        end
    end

    task automatic set_op(input logic [31:0] op, input logic [63:0] d, input logic nv, input int lat);
        in_s    = op;
        lit_d   = d;
        lit_nv  = nv;
        lit_lat = lat;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready && in_valid) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_handshake();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] op, input logic [63:0] d, input logic nv, input int lat);
        set_op(op, d, nv, lat);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(32'd0, 64'd0, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1);
        send(32'h7F7F_FFFF, 64'h47EF_FFFF_E000_0000, 1'b0, 1);
        send(32'h8000_0000, 64'h8000_0000_0000_0000, 1'b0, 1);
        send(32'hFF80_0000, 64'hFFF0_0000_0000_0000, 1'b0, 1);
        send(32'h7F80_0001, 64'h7FF8_0000_0000_0000, 1'b1, 1);
        send(32'hFFC0_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1);
        send(32'h0000_0001, 64'h36A0_0000_0000_0000, 1'b0, 24);
        send(32'h007F_FFFF, 64'h380F_FFFF_C000_0000, 1'b0, 2);
        send(32'h0040_0000, 64'h3800_0000_0000_0000, 1'b0, 2);
        send(32'h0000_0003, 64'h36B8_0000_0000_0000, 1'b0, 23);
        send(32'h8000_0002, 64'hB6B0_0000_0000_0000, 1'b0, 23);
        send(32'h0080_0000, 64'h3810_0000_0000_0000, 1'b0, 1);
        send(32'hC049_0FDB, 64'hC009_21FB_6000_0000, 1'b0, 1);

        // Backpressure with a second operand waiting on in_valid the whole time.
        out_ready = 1'b0;
        set_op(32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1);
        in_valid = 1'b1;
        wait_accept();
        set_op(32'h4000_0000, 64'h4000_0000_0000_0000, 1'b0, 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_handshake();
        wait_accept();
        in_valid = 1'b0;
        wait_handshake();

        // Reset pulse while a subnormal is still normalizing.
        set_op(32'h0000_0001, 64'h36A0_0000_0000_0000, 1'b0, 24);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        send(32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
